// File: rtl/vga_pkg.sv
// Raster timing sets shared by the VGA generator and its users.
// Each axis is described by visible/front/sync/back lengths in pixels or lines.
package vga_pkg;

  typedef struct packed {
    int visible;
    int front;
    int sync;
    int back;
  } axis_timing_t;

  // 640x480@60, 25.175 MHz nominal pixel clock, both syncs active-low
  localparam axis_timing_t VGA640_H   = '{visible: 640, front: 16, sync: 96,  back: 48};
  localparam axis_timing_t VGA640_V   = '{visible: 480, front: 10, sync: 2,   back: 33};
  localparam bit           VGA640_POL = 1'b0;

  // 800x600@60, 40 MHz pixel clock, both syncs active-high
  localparam axis_timing_t VGA800_H   = '{visible: 800, front: 40, sync: 128, back: 88};
  localparam axis_timing_t VGA800_V   = '{visible: 600, front: 1,  sync: 4,   back: 23};
  localparam bit           VGA800_POL = 1'b1;

  function automatic int axis_total(input int vis, input int fp, input int sy, input int bp);
    return vis + fp + sy + bp;
  endfunction

  function automatic logic in_window(input int v, input int lo, input int len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/vga_pix_prescaler.sv
// Pixel clock-enable: divides clk by PIX_DIV while en is high.
// Latency: pix_ce registered, gated combinationally by en. No backpressure; en=0 freezes the divider.
module vga_pix_prescaler #(
  parameter int PIX_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic pix_ce
);

  localparam int            PW   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(PIX_DIV - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_nxt;
  logic          ce_q;

  always_comb begin
    cnt_nxt = cnt_q + PW'(1);
    if (cnt_q == LAST) begin
      cnt_nxt = '0;
    end
  end

  // ce_q tracks "divider sits at its last phase"; with PIX_DIV=1 it stays high once running
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else if (en) begin
      cnt_q <= cnt_nxt;
      ce_q  <= (cnt_nxt == LAST);
    end
  end

  assign pix_ce = ce_q & en;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: counters, sync/blank, line/frame strobes, frame count.
// Latency: sync/blank registered from next-state counters, zero skew to col_o/row_o. en=0 freezes everything.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = VGA640_H.visible,
  parameter int H_FRONT    = VGA640_H.front,
  parameter int H_SYNC     = VGA640_H.sync,
  parameter int H_BACK     = VGA640_H.back,
  parameter int V_VISIBLE  = VGA640_V.visible,
  parameter int V_FRONT    = VGA640_V.front,
  parameter int V_SYNC     = VGA640_V.sync,
  parameter int V_BACK     = VGA640_V.back,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int PIX_DIV    = 2,
  parameter int CNT_W      = 10,
  parameter int FRM_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             pix_ce,
  output logic [CNT_W-1:0] col_o,
  output logic [CNT_W-1:0] row_o,
  output logic             sync_h,
  output logic             sync_v,
  output logic             blank_n,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int               H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int               V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic             HS_ACT  = (H_SYNC_POL != 0);
  localparam logic             VS_ACT  = (V_SYNC_POL != 0);

  logic [CNT_W-1:0] col_q;
  logic [CNT_W-1:0] row_q;
  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;
  logic [FRM_W-1:0] frame_q;
  logic             frame_wrap;
  logic             wrapped_q;
  logic             hs_nxt;
  logic             vs_nxt;
  logic             vis_nxt;
  logic             sync_h_q;
  logic             sync_v_q;
  logic             blank_n_q;

  vga_pix_prescaler #(
    .PIX_DIV(PIX_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .pix_ce(pix_ce)
  );

  always_comb begin
    col_nxt    = col_q + CNT_W'(1);
    row_nxt    = row_q;
    frame_wrap = 1'b0;
    if (col_q == H_LAST) begin
      col_nxt = '0;
      if (row_q == V_LAST) begin
        row_nxt    = '0;
        frame_wrap = 1'b1;
      end else begin
        row_nxt = row_q + CNT_W'(1);
      end
    end
    hs_nxt  = in_window(int'(col_nxt), H_VISIBLE + H_FRONT, H_SYNC);
    vs_nxt  = in_window(int'(row_nxt), V_VISIBLE + V_FRONT, V_SYNC);
    vis_nxt = (int'(col_nxt) < H_VISIBLE) && (int'(row_nxt) < V_VISIBLE);
  end

  // wrapped_q suppresses the frame strobe on the very first pixel after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q     <= '0;
      row_q     <= '0;
      frame_q   <= '0;
      wrapped_q <= 1'b0;
      sync_h_q  <= ~HS_ACT;
      sync_v_q  <= ~VS_ACT;
      blank_n_q <= 1'b1;
    end else if (pix_ce) begin
      col_q     <= col_nxt;
      row_q     <= row_nxt;
      sync_h_q  <= hs_nxt ? HS_ACT : ~HS_ACT;
      sync_v_q  <= vs_nxt ? VS_ACT : ~VS_ACT;
      blank_n_q <= vis_nxt;
      if (frame_wrap) begin
        frame_q   <= frame_q + FRM_W'(1);
        wrapped_q <= 1'b1;
      end
    end
  end

  assign col_o       = col_q;
  assign row_o       = row_q;
  assign sync_h      = sync_h_q;
  assign sync_v      = sync_v_q;
  assign blank_n     = blank_n_q;
  assign frame_cnt   = frame_q;
  assign line_start  = pix_ce && (col_q == '0);
  assign frame_start = line_start && (row_q == '0) && wrapped_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: instance A uses 640x480 defaults (PIX_DIV=2), instance B a short
// 9-line frame with PIX_DIV=1, active-high hsync and a 2-bit frame counter.
module tb_vga_timing_gen;

  typedef struct {
    string name;
    int    idx;
    int    col;
    int    row;
    bit    sh;
    bit    sv;
    bit    bl;
    bit    ls;
    bit    fs;
    int    fc;
    int    cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       a_reset, a_en, b_reset, b_en;
  logic       a_pix_ce, a_sync_h, a_sync_v, a_blank_n, a_line_start, a_frame_start;
  logic       b_pix_ce, b_sync_h, b_sync_v, b_blank_n, b_line_start, b_frame_start;
  logic [9:0] a_col, a_row, b_col, b_row;
  logic [15:0] a_fcnt;
  logic [1:0] b_fcnt;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ra, rb;
  int   n_vec = 0;
  int   n_err = 0;
  int   a_cnt = 0, a_cc = 0, a_base = 0;
  int   b_cnt = 0, b_cc = 0, b_base = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_a (
    .clk(clk), .reset(a_reset), .en(a_en), .pix_ce(a_pix_ce),
    .col_o(a_col), .row_o(a_row), .sync_h(a_sync_h), .sync_v(a_sync_v),
    .blank_n(a_blank_n), .line_start(a_line_start), .frame_start(a_frame_start),
    .frame_cnt(a_fcnt)
  );

  vga_timing_gen #(
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_SYNC_POL(1), .PIX_DIV(1), .FRM_W(2)
  ) u_b (
    .clk(clk), .reset(b_reset), .en(b_en), .pix_ce(b_pix_ce),
    .col_o(b_col), .row_o(b_row), .sync_h(b_sync_h), .sync_v(b_sync_v),
    .blank_n(b_blank_n), .line_start(b_line_start), .frame_start(b_frame_start),
    .frame_cnt(b_fcnt)
  );

  function automatic exp_t mk(input string name, input int idx, input int col, input int row,
                              input bit sh, input bit sv, input bit bl, input bit ls, input bit fs,
                              input int fc, input int cyc);
    exp_t r;
    r.name = name; r.idx = idx; r.col = col; r.row = row;
    r.sh = sh; r.sv = sv; r.bl = bl; r.ls = ls; r.fs = fs; r.fc = fc; r.cyc = cyc;
    return r;
  endfunction

  task automatic cmp(input exp_t r, input int col, input int row, input bit sh, input bit sv,
                     input bit bl, input bit ls, input bit fs, input int fc, input int cyc);
    n_vec++;
    if (col != r.col || row != r.row || sh != r.sh || sv != r.sv || bl != r.bl ||
        ls != r.ls || fs != r.fs || fc != r.fc || (r.cyc >= 0 && cyc != r.cyc)) begin
      n_err++;
      $display("FAIL %s: got col=%0d row=%0d hs=%0b vs=%0b blank_n=%0b ls=%0b fs=%0b fcnt=%0d clk=%0d, want col=%0d row=%0d hs=%0b vs=%0b blank_n=%0b ls=%0b fs=%0b fcnt=%0d clk=%0d",
               r.name, col, row, sh, sv, bl, ls, fs, fc, cyc,
               r.col, r.row, r.sh, r.sv, r.bl, r.ls, r.fs, r.fc, r.cyc);
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Monitors: count pix_ce events since reset; compare when the head record's index comes up
  always @(negedge clk) begin
    if (a_reset) begin
      a_cnt = 0;
    end else if (a_pix_ce) begin
      if (a_cnt == 0) a_base = a_cc;
      if (qa.size() > 0 && qa[0].idx == a_cnt) begin
        ra = qa.pop_front();
        cmp(ra, int'(a_col), int'(a_row), a_sync_h, a_sync_v, a_blank_n, a_line_start,
            a_frame_start, int'(a_fcnt), a_cc - a_base);
      end
      a_cnt++;
    end
    a_cc++;
  end

  always @(negedge clk) begin
    if (b_reset) begin
      b_cnt = 0;
    end else if (b_pix_ce) begin
      if (b_cnt == 0) b_base = b_cc;
      if (qb.size() > 0 && qb[0].idx == b_cnt) begin
        rb = qb.pop_front();
        cmp(rb, int'(b_col), int'(b_row), b_sync_h, b_sync_v, b_blank_n, b_line_start,
            b_frame_start, int'(b_fcnt), b_cc - b_base);
      end
      b_cnt++;
    end
    b_cc++;
  end

  task automatic run_a();
    bit found;
    qa.push_back(mk("a_px0",          0,   0, 0, 1, 1, 1, 1, 0, 0,    0));
    qa.push_back(mk("a_px1",          1,   1, 0, 1, 1, 1, 0, 0, 0,    2));
    qa.push_back(mk("a_vis_last",   639, 639, 0, 1, 1, 1, 0, 0, 0, 1278));
    qa.push_back(mk("a_blank_first",640, 640, 0, 1, 1, 0, 0, 0, 0, 1280));
    qa.push_back(mk("a_pre_hs",     655, 655, 0, 1, 1, 0, 0, 0, 0, 1310));
    qa.push_back(mk("a_hs_first",   656, 656, 0, 0, 1, 0, 0, 0, 0, 1312));
    qa.push_back(mk("a_hs_last",    751, 751, 0, 0, 1, 0, 0, 0, 0, 1502));
    qa.push_back(mk("a_post_hs",    752, 752, 0, 1, 1, 0, 0, 0, 0, 1504));
    qa.push_back(mk("a_line_end",   799, 799, 0, 1, 1, 0, 0, 0, 0, 1598));
    qa.push_back(mk("a_line1",      800,   0, 1, 1, 1, 1, 1, 0, 0, 1600));
    qa.push_back(mk("a_line2",     1600,   0, 2, 1, 1, 1, 1, 0, 0, 3200));
    qa.push_back(mk("a_frz_col",   1700, 100, 2, 1, 1, 1, 0, 0, 0, 3410));
    qa.push_back(mk("a_resume",    1701, 101, 2, 1, 1, 1, 0, 0, 0, 3412));

    a_reset = 1'b1;
    a_en    = 1'b1;
    repeat (3) @(negedge clk);
    check("a_reset_pix_ce", int'(a_pix_ce), 0);
    cmp(mk("a_reset_state", -1, 0, 0, 1, 1, 1, 0, 0, 0, -1), int'(a_col), int'(a_row),
        a_sync_h, a_sync_v, a_blank_n, a_line_start, a_frame_start, int'(a_fcnt), -1);
    a_reset = 1'b0;

    found = 1'b0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      if (a_row == 10'd2 && a_col == 10'd100) found = 1'b1;
    end
    if (!found) begin
      timed_out("a_wait_col100");
    end else begin
      a_en = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        check("a_frozen_col", int'(a_col), 100);
        check("a_frozen_pix_ce", int'(a_pix_ce), 0);
      end
      a_en = 1'b1;
    end

    for (int i = 0; i < 2000 && qa.size() != 0; i++) @(negedge clk);
    if (qa.size() != 0) timed_out("a_drain");
  endtask

  task automatic run_b();
    bit found;
    qb.push_back(mk("b_px0",           0,   0, 0, 0, 1, 1, 1, 0, 0,     0));
    qb.push_back(mk("b_px1",           1,   1, 0, 0, 1, 1, 0, 0, 0,     1));
    qb.push_back(mk("b_pre_hs",      655, 655, 0, 0, 1, 0, 0, 0, 0,   655));
    qb.push_back(mk("b_hs_first",    656, 656, 0, 1, 1, 0, 0, 0, 0,   656));
    qb.push_back(mk("b_hs_last",     751, 751, 0, 1, 1, 0, 0, 0, 0,   751));
    qb.push_back(mk("b_post_hs",     752, 752, 0, 0, 1, 0, 0, 0, 0,   752));
    qb.push_back(mk("b_line1",       800,   0, 1, 0, 1, 1, 1, 0, 0,   800));
    qb.push_back(mk("b_vis_row3",   2405,   5, 3, 0, 1, 1, 0, 0, 0,  2405));
    qb.push_back(mk("b_vblank",     3200,   0, 4, 0, 1, 0, 1, 0, 0,  3200));
    qb.push_back(mk("b_vs_first",   4000,   0, 5, 0, 0, 0, 1, 0, 0,  4000));
    qb.push_back(mk("b_vs_last",    4810,  10, 6, 0, 0, 0, 0, 0, 0,  4810));
    qb.push_back(mk("b_post_vs",    5600,   0, 7, 0, 1, 0, 1, 0, 0,  5600));
    qb.push_back(mk("b_frame_end",  7199, 799, 8, 0, 1, 0, 0, 0, 0,  7199));
    qb.push_back(mk("b_frame1",     7200,   0, 0, 0, 1, 1, 1, 1, 1,  7200));
    qb.push_back(mk("b_frame2",    14400,   0, 0, 0, 1, 1, 1, 1, 2, 14400));
    qb.push_back(mk("b_frame3",    21600,   0, 0, 0, 1, 1, 1, 1, 3, 21600));
    qb.push_back(mk("b_fcnt_wrap", 28800,   0, 0, 0, 1, 1, 1, 1, 0, 28800));
    qb.push_back(mk("b_frame5",    36000,   0, 0, 0, 1, 1, 1, 1, 1, 36000));

    b_reset = 1'b1;
    b_en    = 1'b1;
    repeat (3) @(negedge clk);
    check("b_reset_pix_ce", int'(b_pix_ce), 0);
    b_reset = 1'b0;

    for (int i = 0; i < 40000 && qb.size() != 0; i++) @(negedge clk);
    if (qb.size() != 0) timed_out("b_drain_frames");

    found = 1'b0;
    for (int i = 0; i < 8000 && !found; i++) begin
      @(negedge clk);
      if (b_row == 10'd5) found = 1'b1;
    end
    if (!found) begin
      timed_out("b_wait_row5");
    end else begin
      b_reset = 1'b1;
      @(negedge clk);
      check("b_midrst_pix_ce", int'(b_pix_ce), 0);
      cmp(mk("b_midrst_state", -1, 0, 0, 0, 1, 1, 0, 0, 0, -1), int'(b_col), int'(b_row),
          b_sync_h, b_sync_v, b_blank_n, b_line_start, b_frame_start, int'(b_fcnt), -1);
      qb.push_back(mk("b_rst_px0",       0, 0, 0, 0, 1, 1, 1, 0, 0,    0));
      qb.push_back(mk("b_rst_px1",       1, 1, 0, 0, 1, 1, 0, 0, 0,    1));
      qb.push_back(mk("b_rst_frame1", 7200, 0, 0, 0, 1, 1, 1, 1, 1, 7200));
      @(negedge clk);
      b_reset = 1'b0;
      for (int i = 0; i < 8000 && qb.size() != 0; i++) @(negedge clk);
      if (qb.size() != 0) timed_out("b_drain_after_reset");
    end
  endtask

  initial begin
    a_reset = 1'b1;
    a_en    = 1'b0;
    b_reset = 1'b1;
    b_en    = 1'b0;
    @(negedge clk);
    fork
      run_a();
      run_b();
    join
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d records still queued", qa.size() + qb.size());
    $fatal(1, "watchdog expired");
  end

endmodule
